// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
//
// Hazard / forwarding scoreboard for the decode stage. It keeps a shift register
// of in-flight destination registers, one entry per downstream stage
// (stage 0 = EX, 1 = MEM, 2 = WB, ...). For each source operand it selects the
// youngest matching stage as the forwarding source. A load that is still too
// young to forward causes a load-use stall. A HALT drains the pipe.
//
// fwd_sel encoding per source: 0 = register file, k = stage k-1.
//
// Optional feature macro: SCOREBOARD_PERF_EN
//   defined     -> saturating hazard_cnt / stall_cnt performance counters
//   not defined -> counter flops removed, hazard_cnt / stall_cnt tied to 0
// -----------------------------------------------------------------------------
module decode_scoreboard #(
  parameter int REGW       = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 2,
  parameter int NUM_SRC    = 2,
  parameter int CNTW       = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        dec_valid,
  input  logic [NUM_SRC*REGW-1:0]                     dec_src,
  input  logic [NUM_SRC-1:0]                          dec_src_used,
  input  logic [REGW-1:0]                             dec_rd,
  input  logic                                        dec_wr,
  input  logic                                        dec_is_load,
  input  logic                                        dec_halt,
  input  logic                                        flush,
  output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0]     fwd_sel,
  output logic                                        stall,
  output logic                                        issue,
  output logic                                        halt_done,
  output logic [CNTW-1:0]                             hazard_cnt,
  output logic [CNTW-1:0]                             stall_cnt
);

  localparam int SELW = $clog2(FWD_STAGES+1);

  // RUN: normal issue. DRAIN: HALT has issued, wait for the pipe to empty.
  // HALTED: pipe empty, only reset leaves this state.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // In-flight stage entries: valid/is_load are control, rd is payload.
  logic [FWD_STAGES-1:0] stg_valid;
  logic [FWD_STAGES-1:0] stg_load;
  logic [REGW-1:0]       stg_rd [FWD_STAGES];

  // Per-source load-use indication (winning match is a load that is too young).
  logic [NUM_SRC-1:0]    load_use;
  logic                  any_load_use;

  // An entry only becomes valid when it really writes a non-zero register.
  logic                  new_valid;
  assign new_valid = issue & dec_wr & (dec_rd != '0);

  // ---------------------------------------------------------------------------
  // Forwarding select: scan oldest to youngest so the youngest match wins.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the loops, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    fwd_sel  = '0;
    load_use = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = FWD_STAGES - 1; s >= 0; s--) begin
        if (dec_src_used[i] &&
            (dec_src[i*REGW +: REGW] != '0) &&
            stg_valid[s] &&
            (stg_rd[s] == dec_src[i*REGW +: REGW])) begin
          fwd_sel[i*SELW +: SELW] = SELW'(s + 1);
          load_use[i]             = stg_load[s] && (s < LOAD_LAT);
        end
      end
    end
  end

  assign any_load_use = |load_use;

  // ---------------------------------------------------------------------------
  // FSM next state plus stall / issue decode. flush outranks stall; in DRAIN
  // and HALTED nothing issues and nothing stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    unique case (state)
      ST_RUN: begin
        stall = dec_valid & any_load_use & ~flush;
        issue = dec_valid & ~any_load_use & ~flush;
        if (dec_halt && issue) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (stg_valid == '0) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM state register; halt_done is decoded straight from this flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign halt_done = (state == ST_HALTED);

  // Control part of the stage shift register: shift every cycle, bubble in
  // stage 0 unless an instruction issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      stg_load  <= '0;
    end else begin
      for (int s = FWD_STAGES - 1; s >= 1; s--) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_load[s]  <= stg_load[s-1];
      end
      stg_valid[0] <= new_valid;
      stg_load[0]  <= new_valid & dec_is_load;
    end
  end

  // Payload part of the stage shift register.
  // NOTE: rd is not reset; it is never looked at while its valid bit is 0,
  // so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int s = FWD_STAGES - 1; s >= 1; s--) begin
      stg_rd[s] <= stg_rd[s-1];
    end
    stg_rd[0] <= dec_rd;
  end

`ifdef SCOREBOARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] hazard_q;
  logic [CNTW-1:0] stall_q;

  // Count issuing cycles that forward at least one operand, and stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_q <= '0;
      stall_q  <= '0;
    end else begin
      if (issue && (fwd_sel != '0) && (hazard_q != '1)) begin
        hazard_q <= hazard_q + 1'b1;
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign hazard_cnt = hazard_q;
  assign stall_cnt  = stall_q;
`else
  assign hazard_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_decode_scoreboard
//
// Directed bench for decode_scoreboard with default parameters
// (REGW=5, FWD_STAGES=3, LOAD_LAT=2, NUM_SRC=2). fwd_sel is {src1, src0},
// two bits each. Inputs change 1 time unit after a rising edge; combinational
// outputs are checked before the next edge, registered ones after it.
// Expected counter values are scaled by PERF so the bench fits both builds.
// -----------------------------------------------------------------------------
module tb_decode_scoreboard;

`ifdef SCOREBOARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic [9:0]  dec_src;
  logic [1:0]  dec_src_used;
  logic [4:0]  dec_rd;
  logic        dec_wr;
  logic        dec_is_load;
  logic        dec_halt;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        issue;
  logic        halt_done;
  logic [31:0] hazard_cnt;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  decode_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_src      (dec_src),
    .dec_src_used (dec_src_used),
    .dec_rd       (dec_rd),
    .dec_wr       (dec_wr),
    .dec_is_load  (dec_is_load),
    .dec_halt     (dec_halt),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .issue        (issue),
    .halt_done    (halt_done),
    .hazard_cnt   (hazard_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decode slot; settles combinational outputs before returning.
  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic hlt, input logic fl);
    dec_valid    = v;
    dec_src      = {s1, s0};
    dec_src_used = used;
    dec_rd       = rd;
    dec_wr       = wr;
    dec_is_load  = ld;
    dec_halt     = hlt;
    flush        = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_fwd_sel",   32'(fwd_sel), 0);
    check("rst_stall",     32'(stall), 0);
    check("rst_issue",     32'(issue), 0);
    check("rst_halt_done", 32'(halt_done), 0);
    check("rst_hazard",    hazard_cnt, 0);
    check("rst_stallcnt",  stall_cnt, 0);

    // 1: add r3 = r1 + r2, then sub r6 = r3 - r7 forwards from EX
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0, 0);
    check("t1_add_fwd",   32'(fwd_sel), 0);
    check("t1_add_issue", 32'(issue), 1);
    tick();
    drive(1, 3, 7, 2'b11, 6, 1, 0, 0, 0);
    check("t1_sub_fwd",   32'(fwd_sel), 4'b0001);
    check("t1_sub_stall", 32'(stall), 0);
    check("t1_sub_issue", 32'(issue), 1);
    tick();
    check("t1_hazard", hazard_cnt, 32'(PERF * 1));

    // 2: lw r5, then add r8 = r5 + r6 stalls two cycles
    drive(1, 1, 0, 2'b01, 5, 1, 1, 0, 0);
    check("t2_lw_fwd", 32'(fwd_sel), 0);
    tick();
    drive(1, 5, 6, 2'b11, 8, 1, 0, 0, 0);
    check("t2_c1_stall", 32'(stall), 1);
    check("t2_c1_issue", 32'(issue), 0);
    check("t2_c1_fwd",   32'(fwd_sel), 4'b1001);
    tick();
    check("t2_c2_stall", 32'(stall), 1);
    check("t2_c2_fwd",   32'(fwd_sel), 4'b1110);
    tick();
    check("t2_c3_stall", 32'(stall), 0);
    check("t2_c3_issue", 32'(issue), 1);
    check("t2_c3_fwd",   32'(fwd_sel), 4'b0011);
    tick();
    check("t2_stallcnt", stall_cnt, 32'(PERF * 2));
    check("t2_hazard",   hazard_cnt, 32'(PERF * 2));

    // 3: r4 in stage 2 and stage 0 -> youngest wins; r0 never matches
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 9, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    tick();
    drive(1, 4, 0, 2'b11, 0, 1, 0, 0, 0);
    check("t3_youngest", 32'(fwd_sel), 4'b0001);
    tick();
    drive(1, 0, 4, 2'b11, 0, 0, 0, 0, 0);
    check("t3_r0_src", 32'(fwd_sel), 4'b1000);
    tick();
    check("t3_hazard", hazard_cnt, 32'(PERF * 4));

    // 4: flush during a load-use stall
    drive(1, 0, 0, 2'b00, 10, 1, 1, 0, 0);
    tick();
    drive(1, 10, 0, 2'b01, 11, 1, 0, 0, 1);
    check("t4_fl_stall", 32'(stall), 0);
    check("t4_fl_issue", 32'(issue), 0);
    tick();
    check("t4_fl_stallcnt", stall_cnt, 32'(PERF * 2));
    check("t4_fl_hazard",   hazard_cnt, 32'(PERF * 4));
    drive(1, 10, 11, 2'b11, 12, 1, 0, 0, 0);
    check("t4_bubble_fwd", 32'(fwd_sel), 4'b0010);
    check("t4_stall",      32'(stall), 1);
    tick();
    check("t4_after_fwd",   32'(fwd_sel), 4'b0011);
    check("t4_after_issue", 32'(issue), 1);
    tick();
    check("t4_stallcnt", stall_cnt, 32'(PERF * 3));
    check("t4_hazard",   hazard_cnt, 32'(PERF * 5));

    // 5: HALT with three writes in flight
    drive(1, 0, 0, 2'b00, 13, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 14, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 15, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    check("t5_halt_issue", 32'(issue), 1);
    tick();
    drive(1, 15, 0, 2'b01, 16, 1, 0, 0, 0);
    check("t5_drain_issue", 32'(issue), 0);
    check("t5_drain_stall", 32'(stall), 0);
    check("t5_drain_fwd",   32'(fwd_sel), 4'b0010);
    check("t5_drain_done",  32'(halt_done), 0);
    tick();
    check("t5_d1_done",  32'(halt_done), 0);
    check("t5_d1_issue", 32'(issue), 0);
    tick();
    check("t5_empty_done", 32'(halt_done), 0);
    tick();
    check("t5_halt_done", 32'(halt_done), 1);
    for (int k = 0; k < 3; k++) begin
      dec_valid = ~dec_valid;
      tick();
      check("t5_hold_done",  32'(halt_done), 1);
      check("t5_hold_issue", 32'(issue), 0);
    end

    // 6: leave HALTED by reset, refill, halt, then reset during DRAIN
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_leave_halted", 32'(halt_done), 0);
    drive(1, 0, 0, 2'b00, 20, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 21, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 22, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    check("t6_halt_issue", 32'(issue), 1);
    tick();
    drive(1, 22, 21, 2'b11, 0, 0, 0, 0, 0);
    check("t6_drain_issue", 32'(issue), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t6_rst_fwd",   32'(fwd_sel), 0);
    check("t6_rst_stall", 32'(stall), 0);
    check("t6_rst_issue", 32'(issue), 0);
    check("t6_rst_done",  32'(halt_done), 0);
    check("t6_rst_haz",   hazard_cnt, 0);
    check("t6_rst_stc",   stall_cnt, 0);
    drive(1, 22, 21, 2'b11, 0, 0, 0, 0, 0);
    check("t6_cleared_fwd", 32'(fwd_sel), 0);
    check("t6_run_issue",   32'(issue), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
